or1200_if_buf: RTL and testbench
================================

OR1200_IF_BUF -- requirements
Module: or1200_if_buf

Interface
REQ-001 The block SHALL have parameter NOP_INSN, default 32'h1541_0000, the void l.nop presented to ctrl when no valid instruction exists.
REQ-002 The block SHALL have parameter DEPTH, default 2, the number of skid-buffer entries; only the value 2 is supported.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on posedge clk.
REQ-004 The block SHALL have port rst, input, 1, a synchronous active-low reset.
REQ-005 The block SHALL have port icpu_dat_i, input, 32, the instruction word from the IC/IMMU path.
REQ-006 The block SHALL have port icpu_adr_i, input, 32, the address of icpu_dat_i.
REQ-007 The block SHALL have port icpu_ack_i, input, 1, marking icpu_dat_i/icpu_adr_i valid this cycle.
REQ-008 The block SHALL have port icpu_err_i, input, 1, a bus error accompanying the ack.
REQ-009 The block SHALL have port if_freeze, input, 1, holding IF→ID hand-off when ctrl/freeze stalls.
REQ-010 The block SHALL have port if_flushpipe, input, 1, discarding all buffered instructions.
REQ-011 The block SHALL have port if_insn, output, 32, the instruction presented to or1200_ctrl.
REQ-012 The block SHALL have port if_pc, output, 32, the PC of if_insn.
REQ-013 The block SHALL have port if_valid, output, 1, high when if_insn is a real fetched instruction.
REQ-014 The block SHALL have port except_ibuserr, output, 1, the bus error tagged to if_insn.
REQ-015 The block SHALL have port if_full, output, 1, high when both entries are occupied; genpc stops issuing fetches.

Function
REQ-016 Each entry SHALL hold {insn[31:0], pc[31:0], err}, and occupancy SHALL be a 2-bit count 0..2 with states EMPTY, ONE, TWO.
REQ-017 A fetch SHALL be accepted on icpu_ack_i=1 and !if_flushpipe; an ack arriving with if_full=1 SHALL be dropped and flagged by an assertion.
REQ-018 The head entry SHALL be consumed on a cycle with if_freeze=0 and count>0.
REQ-019 Transitions: EMPTY→ONE on accept; ONE→TWO on accept with freeze; ONE→EMPTY on consume without accept; ONE stays ONE on accept plus consume; TWO→ONE on consume.
REQ-020 Order SHALL be strictly FIFO; the second entry SHALL shift into the head on consume, with no wrap pointers.
REQ-021 When count=0, outputs SHALL be if_insn=NOP_INSN, if_valid=0, and except_ibuserr=0, with if_pc holding its last value.
REQ-022 When if_flushpipe=1, count SHALL go to 0 next cycle, and an ack in the same cycle SHALL be discarded.
REQ-023 While if_freeze=1, if_insn, if_pc and if_valid SHALL remain stable.
REQ-024 icpu_err_i=1 SHALL store insn=NOP_INSN with err=1; except_ibuserr SHALL be asserted while that entry is the head.
REQ-025 if_full SHALL be registered and SHALL equal (count==2).

Reset
REQ-026 On a clk edge with rst=0, the block SHALL set count=0, if_insn=NOP_INSN, if_pc=32'h0, if_valid=0, except_ibuserr=0 and if_full=0.
REQ-027 Reset mid-operation SHALL discard all entries without emitting any partial instruction.

Configuration
REQ-028 With OR1200_IF_BUF_BYPASS_EN defined, when count=0 and an ack is accepted with if_freeze=0, icpu_dat_i/icpu_adr_i/icpu_err_i SHALL drive the outputs combinationally that cycle and SHALL not be stored, giving 0-cycle latency.
REQ-029 Without OR1200_IF_BUF_BYPASS_EN, every accepted fetch SHALL be registered first, giving 1-cycle latency from ack to if_valid.

Structure
REQ-030 Package or1200_if_buf_pkg SHALL hold the entry struct typedef, the state enum (EMPTY/ONE/TWO), and the NOP_INSN default constant.
REQ-031 The block SHALL contain no sub-modules; the two-entry store SHALL be inline registers.

Verification
REQ-032 Single fetch, no bypass: ack with dat=32'h9C21_0004, adr=32'h100 → next cycle if_insn=32'h9C21_0004, if_pc=32'h100, if_valid=1.
REQ-033 Freeze fill: if_freeze=1, two acks (adr 0x100, 0x104) → if_full=1; release freeze → 0x100 then 0x104 on consecutive cycles.
REQ-034 Flush with simultaneous ack: count=2, if_flushpipe=1 with ack adr 0x200 → next cycle count=0, if_insn=32'h1541_0000, if_valid=0.
REQ-035 Bus error: ack with icpu_err_i=1 at adr 0x300 → if_insn=32'h1541_0000, except_ibuserr=1, if_pc=0x300.
REQ-036 Mid-operation reset: rst=0 while count=2 → next cycle all outputs at reset values; no stale instruction after rst=1.
REQ-037 Bypass mode: with OR1200_IF_BUF_BYPASS_EN defined, ack at adr 0x400 while empty and unfrozen → if_valid=1 and if_pc=0x400 in the same cycle, with count remaining 0.

Source files
------------

// File: rtl/or1200_if_buf_pkg.sv
// ---------------------------------------------------------------------------
// or1200_if_buf_pkg
// Shared types and constants for the IF skid buffer:
//   entry_t     - one buffered fetch {insn, pc, err}
//   state_t     - buffer occupancy (EMPTY / ONE / TWO)
//   NOP_INSN_DEFAULT - void l.nop shown to ctrl when nothing valid is held
//   make_entry  - builds an entry from a fetch, replacing the word on bus error
// ---------------------------------------------------------------------------
package or1200_if_buf_pkg;

    localparam logic [31:0] NOP_INSN_DEFAULT = 32'h1541_0000;

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic        err;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // A faulting fetch carries no usable instruction word, so a nop is stored
    // in its place and only the error flag and address survive.
    function automatic entry_t make_entry(input logic [31:0] dat,
                                          input logic [31:0] adr,
                                          input logic        err,
                                          input logic [31:0] nop);
        entry_t e;
        e.insn = err ? nop : dat;
        e.pc   = adr;
        e.err  = err;
        return e;
    endfunction

endpackage

// File: rtl/or1200_if_buf.sv
// ---------------------------------------------------------------------------
// or1200_if_buf
// Two-entry FIFO skid buffer between the IC/IMMU fetch path and or1200_ctrl.
// Optional feature macro: OR1200_IF_BUF_BYPASS_EN (0-cycle latency when empty).
//
// Ports
//   clk            in   clock, all logic on posedge
//   rst            in   synchronous reset, active low
//   icpu_dat_i     in   fetched instruction word
//   icpu_adr_i     in   address of icpu_dat_i
//   icpu_ack_i     in   fetch data valid this cycle
//   icpu_err_i     in   bus error accompanying the ack
//   if_freeze      in   stall IF->ID hand-off
//   if_flushpipe   in   discard everything buffered (and a same-cycle ack)
//   if_insn        out  instruction presented to ctrl (nop when none)
//   if_pc          out  PC of if_insn (holds last value when empty)
//   if_valid       out  if_insn is a real fetched instruction
//   except_ibuserr out  bus error tagged to if_insn
//   if_full        out  both entries occupied, genpc must stop fetching
// ---------------------------------------------------------------------------
module or1200_if_buf
    import or1200_if_buf_pkg::*;
#(
    parameter logic [31:0] NOP_INSN = NOP_INSN_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] icpu_dat_i,
    input  logic [31:0] icpu_adr_i,
    input  logic        icpu_ack_i,
    input  logic        icpu_err_i,
    input  logic        if_freeze,
    input  logic        if_flushpipe,
    output logic [31:0] if_insn,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        except_ibuserr,
    output logic        if_full
);

    localparam logic [1:0] FULL_CNT = DEPTH[1:0];

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    logic   full_q, full_d;

    entry_t new_e;
    logic   accept, consume, bypass;

    assign new_e   = make_entry(icpu_dat_i, icpu_adr_i, icpu_err_i, NOP_INSN);
    // An ack while full has nowhere to go and is dropped.
    assign accept  = icpu_ack_i & ~if_flushpipe & ~full_q;
    assign consume = ~if_freeze & (state_q != EMPTY);

`ifdef OR1200_IF_BUF_BYPASS_EN
    assign bypass = accept & ~if_freeze & (state_q == EMPTY);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (if_flushpipe) begin
            // head pc is kept so if_pc holds its last value after the flush
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (bypass) begin
                        // consumed on the fly; only the pc is kept for if_pc
                        head_d.pc = new_e.pc;
                    end else if (accept) begin
                        head_d  = new_e;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        head_d = new_e;
                    end else if (accept) begin
                        tail_d  = new_e;
                        state_d = TWO;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (consume) begin
                        head_d  = tail_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        full_d = (state_d == FULL_CNT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            head_q  <= '{insn: NOP_INSN, pc: 32'h0, err: 1'b0};
            tail_q  <= '{insn: NOP_INSN, pc: 32'h0, err: 1'b0};
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            full_q  <= full_d;
        end
    end

    always_comb begin
        if (bypass) begin
            if_insn        = new_e.insn;
            if_pc          = new_e.pc;
            if_valid       = 1'b1;
            except_ibuserr = new_e.err;
        end else if (state_q != EMPTY) begin
            if_insn        = head_q.insn;
            if_pc          = head_q.pc;
            if_valid       = 1'b1;
            except_ibuserr = head_q.err;
        end else begin
            if_insn        = NOP_INSN;
            if_pc          = head_q.pc;
            if_valid       = 1'b0;
            except_ibuserr = 1'b0;
        end
    end

    assign if_full = full_q;

    // genpc must not issue a fetch that returns while the buffer is full.
    ack_when_full: assert property (@(posedge clk) disable iff (!rst)
        !(icpu_ack_i && full_q && !if_flushpipe));

endmodule

// File: tb/tb_or1200_if_buf.sv
module tb_or1200_if_buf;

    localparam logic [31:0] NOP = 32'h1541_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] icpu_dat_i = '0;
    logic [31:0] icpu_adr_i = '0;
    logic        icpu_ack_i = 1'b0;
    logic        icpu_err_i = 1'b0;
    logic        if_freeze = 1'b0;
    logic        if_flushpipe = 1'b0;
    logic [31:0] if_insn;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        except_ibuserr;
    logic        if_full;

    or1200_if_buf dut (
        .clk            (clk),
        .rst            (rst),
        .icpu_dat_i     (icpu_dat_i),
        .icpu_adr_i     (icpu_adr_i),
        .icpu_ack_i     (icpu_ack_i),
        .icpu_err_i     (icpu_err_i),
        .if_freeze      (if_freeze),
        .if_flushpipe   (if_flushpipe),
        .if_insn        (if_insn),
        .if_pc          (if_pc),
        .if_valid       (if_valid),
        .except_ibuserr (except_ibuserr),
        .if_full        (if_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r_n, ack, err, frz, fl;
        logic [31:0] dat, adr;
        logic        e_valid;
        logic [31:0] e_insn, e_pc;
        logic        e_berr, e_full;
    } vec_t;

    typedef struct {
        logic [31:0] insn, pc;
        logic        err;
    } fetch_t;

    vec_t   tbl[$];
    vec_t   exp_q[$];
    fetch_t fetch_q[$];
    int     checks = 0;
    int     errors = 0;
    int     pops = 0;
    logic   done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic r_n, ack, err, frz, fl,
                               input logic [31:0] dat, adr,
                               input logic e_valid, input logic [31:0] e_insn, e_pc,
                               input logic e_berr, e_full);
        vec_t x;
        x.r_n = r_n; x.ack = ack; x.err = err; x.frz = frz; x.fl = fl;
        x.dat = dat; x.adr = adr; x.e_valid = e_valid; x.e_insn = e_insn;
        x.e_pc = e_pc; x.e_berr = e_berr; x.e_full = e_full;
        return x;
    endfunction

    task automatic drive(input vec_t x);
        fetch_t f;
        rst = x.r_n; icpu_ack_i = x.ack; icpu_err_i = x.err;
        if_freeze = x.frz; if_flushpipe = x.fl;
        icpu_dat_i = x.dat; icpu_adr_i = x.adr;
        if (x.r_n && x.ack && !x.fl) begin
            f.insn = x.err ? NOP : x.dat;
            f.pc   = x.adr;
            f.err  = x.err;
            fetch_q.push_back(f);
        end
        exp_q.push_back(x);
    endtask

    task automatic check_out(input vec_t x, input int row);
        string s;
        s = $sformatf("row%0d", row);
        chk({s, ".valid"}, {31'd0, if_valid}, {31'd0, x.e_valid});
        chk({s, ".insn"}, if_insn, x.e_insn);
        chk({s, ".pc"}, if_pc, x.e_pc);
        chk({s, ".ibuserr"}, {31'd0, except_ibuserr}, {31'd0, x.e_berr});
        chk({s, ".full"}, {31'd0, if_full}, {31'd0, x.e_full});
    endtask

    // Consumption monitor: the head leaves on the next edge when valid and
    // unfrozen; it must match the oldest accepted fetch.
    always @(negedge clk) begin
        if (!done) begin
            if (!rst || if_flushpipe) begin
                fetch_q.delete();
            end else if (if_valid && !if_freeze) begin
                if (fetch_q.size() == 0) begin
                    chk("order.unexpected", if_pc, 32'hFFFF_FFFF);
                end else begin
                    fetch_t f;
                    f = fetch_q.pop_front();
                    pops++;
                    chk("order.insn", if_insn, f.insn);
                    chk("order.pc", if_pc, f.pc);
                    chk("order.err", {31'd0, except_ibuserr}, {31'd0, f.err});
                end
            end
        end
    end

    initial begin
        vec_t idle, x;
        // r_n ack err frz fl dat adr | valid insn pc berr full
        tbl.push_back(v(0,0,0,0,0, 0, 0,                       0, NOP, 32'h0, 0, 0));
        tbl.push_back(v(1,0,0,0,0, 0, 0,                       0, NOP, 32'h0, 0, 0));
        tbl.push_back(v(1,1,0,0,0, 32'h9C21_0004, 32'h100,     1, 32'h9C21_0004, 32'h100, 0, 0));
        tbl.push_back(v(1,0,0,0,0, 0, 0,                       0, NOP, 32'h100, 0, 0));
        tbl.push_back(v(1,1,0,1,0, 32'h1111_0000, 32'h100,     1, 32'h1111_0000, 32'h100, 0, 0));
        tbl.push_back(v(1,1,0,1,0, 32'h2222_0000, 32'h104,     1, 32'h1111_0000, 32'h100, 0, 1));
        tbl.push_back(v(1,0,0,1,0, 0, 0,                       1, 32'h1111_0000, 32'h100, 0, 1));
        tbl.push_back(v(1,0,0,0,0, 0, 0,                       1, 32'h2222_0000, 32'h104, 0, 0));
        tbl.push_back(v(1,0,0,0,0, 0, 0,                       0, NOP, 32'h104, 0, 0));
        tbl.push_back(v(1,1,0,1,0, 32'h3333_0000, 32'h180,     1, 32'h3333_0000, 32'h180, 0, 0));
        tbl.push_back(v(1,1,0,1,0, 32'h4444_0000, 32'h184,     1, 32'h3333_0000, 32'h180, 0, 1));
        tbl.push_back(v(1,1,0,1,1, 32'h5555_0000, 32'h200,     0, NOP, 32'h180, 0, 0));
        tbl.push_back(v(1,0,0,0,0, 0, 0,                       0, NOP, 32'h180, 0, 0));
        tbl.push_back(v(1,1,1,0,0, 32'hDEAD_BEEF, 32'h300,     1, NOP, 32'h300, 1, 0));
        tbl.push_back(v(1,0,0,0,0, 0, 0,                       0, NOP, 32'h300, 0, 0));
        tbl.push_back(v(1,1,0,1,0, 32'h6666_0000, 32'h400,     1, 32'h6666_0000, 32'h400, 0, 0));
        tbl.push_back(v(1,1,0,0,0, 32'h7777_0000, 32'h404,     1, 32'h7777_0000, 32'h404, 0, 0));
        tbl.push_back(v(1,0,0,0,0, 0, 0,                       0, NOP, 32'h404, 0, 0));
        tbl.push_back(v(1,1,0,1,0, 32'h8888_0000, 32'h500,     1, 32'h8888_0000, 32'h500, 0, 0));
        tbl.push_back(v(1,1,0,1,0, 32'h9999_0000, 32'h504,     1, 32'h8888_0000, 32'h500, 0, 1));
        tbl.push_back(v(0,0,0,1,0, 0, 0,                       0, NOP, 32'h0, 0, 0));
        tbl.push_back(v(1,0,0,0,0, 0, 0,                       0, NOP, 32'h0, 0, 0));
        tbl.push_back(v(1,0,0,0,0, 0, 0,                       0, NOP, 32'h0, 0, 0));
        idle = v(1,0,0,0,0, 0, 0, 0, NOP, 32'h0, 0, 0);

`ifndef OR1200_IF_BUF_BYPASS_EN
        for (int i = 0; i <= tbl.size(); i++) begin
            @(posedge clk);
            #1;
            if (i > 0) begin
                if (exp_q.size() == 0) chk("exp_q.empty", 32'd0, 32'd1);
                else check_out(exp_q.pop_front(), i - 1);
            end
            #1;
            if (i < tbl.size()) drive(tbl[i]);
        end
        @(negedge clk);
        chk("order.pops", pops, 6);
        chk("order.leftover", fetch_q.size(), 0);
`else
        // reset, then a single ack while empty and unfrozen
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #2;
            drive(tbl[i]);
            void'(exp_q.pop_front());
        end
        @(posedge clk); #2;
        x = v(1,1,0,0,0, 32'hABCD_0001, 32'h400, 1, 32'hABCD_0001, 32'h400, 0, 0);
        drive(x);
        void'(exp_q.pop_front());
        #1;
        check_out(x, 100);
        @(posedge clk); #2;
        drive(idle);
        void'(exp_q.pop_front());
        #1;
        x = v(1,0,0,0,0, 0, 0, 0, NOP, 32'h400, 0, 0);
        check_out(x, 101);
        @(negedge clk);
        chk("bypass.pops", pops, 1);
`endif
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
